// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared sizing constants, default coefficient set and FSM state type for the
// time-multiplexed FIR filter (fir_compiler) and its MAC (fir_mac).
// ---------------------------------------------------------------------------
package fir_pkg;

  // Default filter geometry.
  localparam int unsigned NTAPS = 16;
  localparam int unsigned DW    = 24;
  localparam int unsigned CW    = 16;
  localparam int unsigned OW    = 48;

  // Full-precision accumulator: product width plus growth for NTAPS additions.
  localparam int unsigned ACCW  = DW + CW + $clog2(NTAPS);

  // Coefficients packed flat, tap k occupying bits [k*CW +: CW].
  // The leftmost literal is tap NTAPS-1; the set is symmetric, so the
  // ordering reads the same either way.
  localparam logic [NTAPS*CW-1:0] DEFAULT_COEFFS = {
    16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
    16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1
  };

  // Sequencer states: wait for a sample, run the taps, publish the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage : fir_pkg

// File: rtl/fir_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
// Registered signed multiply-accumulate: acc <= clr ? 0 : acc + a*b (when en).
// The product is sign-extended to the accumulator width; no rounding and no
// saturation -- the accumulator is sized so it cannot overflow.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (clears the accumulator)
//   i_clr    synchronous clear, has priority over i_en
//   i_en     accumulate a*b this cycle
//   i_a      signed multiplicand (sample)
//   i_b      signed multiplier (coefficient)
//   o_acc    registered signed accumulator
// ---------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned AW    = fir_pkg::DW,
  parameter int unsigned BW    = fir_pkg::CW,
  parameter int unsigned ACC_W = fir_pkg::ACCW
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [AW-1:0]    i_a,
  input  logic signed [BW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int unsigned PW = AW + BW;

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] r_acc;

  // Both operands signed, so this is a true signed AW x BW multiply.
  assign w_prod = i_a * i_b;

  // Accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule : fir_mac

// File: rtl/fir_compiler.sv
// ---------------------------------------------------------------------------
// fir_compiler
// Single-rate FIR filter with AXI4-Stream sample in / result out, sharing one
// multiply-accumulate across all taps. One sample is accepted, NTAPS products
// are accumulated one per clock, then the full-precision result is published
// as a one-cycle m_axis_data_tvalid pulse. Coefficients are fixed at
// elaboration; the config and reload channels are accepted but have no effect.
//
// Ports
//   aclk                  clock, rising edge
//   aresetn               asynchronous active-low reset
//   s_axis_config_tvalid  reserved, ignored
//   s_axis_reload_tvalid  reserved, ignored
//   s_axis_data_tvalid    input sample valid
//   s_axis_data_tready    registered ready; high only in IDLE
//   s_axis_data_tdata     signed input sample x[n]
//   m_axis_data_tvalid    registered one-cycle result strobe (no backpressure)
//   m_axis_data_tdata     registered signed result y[n], held between strobes
//
// Latency: accept on edge T0, result valid after edge T0+NTAPS+1, next sample
// may be accepted on edge T0+NTAPS+2.
// ---------------------------------------------------------------------------
module fir_compiler
#(
  parameter int unsigned          NTAPS  = fir_pkg::NTAPS,
  parameter int unsigned          DW     = fir_pkg::DW,
  parameter int unsigned          CW     = fir_pkg::CW,
  parameter int unsigned          OW     = fir_pkg::OW,
  parameter logic [NTAPS*CW-1:0]  COEFFS = fir_pkg::DEFAULT_COEFFS
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_config_tvalid,
  input  logic          s_axis_reload_tvalid,
  input  logic          s_axis_data_tvalid,
  output logic          s_axis_data_tready,
  input  logic [DW-1:0] s_axis_data_tdata,
  output logic          m_axis_data_tvalid,
  output logic [OW-1:0] m_axis_data_tdata
);

  import fir_pkg::*;

  localparam int unsigned ACC_W = DW + CW + $clog2(NTAPS);
  localparam int unsigned KW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  // Sequencer
  state_e r_state;
  state_e w_state_nxt;
  logic   w_accept;
  logic   w_mac_clr;
  logic   w_mac_en;
  logic   w_out_load;
  logic   w_tready_nxt;

  // Datapath
  logic        [KW-1:0]    r_k;
  logic signed [DW-1:0]    r_dly  [NTAPS];
  logic signed [CW-1:0]    w_coef [NTAPS];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [OW-1:0]    r_mdata;
  logic                    r_mvalid;
  logic                    r_tready;

  // Reserved channels are deliberately ignored.
  logic w_unused;
  assign w_unused = s_axis_config_tvalid ^ s_axis_reload_tvalid;

  // Unpack the flat coefficient parameter into a per-tap table.
  for (genvar g = 0; g < NTAPS; g++) begin : g_coef
    assign w_coef[g] = COEFFS[g*CW +: CW];
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_mac_clr    = 1'b0;
    w_mac_en     = 1'b0;
    w_out_load   = 1'b0;
    w_tready_nxt = r_tready;
    case (r_state)
      IDLE: begin
        // tready is raised on the first edge out of reset / out of OUT.
        w_tready_nxt = 1'b1;
        if (s_axis_data_tvalid && r_tready) begin
          w_accept     = 1'b1;
          w_mac_clr    = 1'b1;
          w_tready_nxt = 1'b0;
          w_state_nxt  = MAC;
        end
      end
      MAC: begin
        w_mac_en     = 1'b1;
        w_tready_nxt = 1'b0;
        if (r_k == KW'(NTAPS - 1)) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        // Raising tready here lets the next sample land on the edge right
        // after the result strobe, giving NTAPS+2 clocks per sample.
        w_out_load   = 1'b1;
        w_tready_nxt = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_tready_nxt = 1'b0;
      end
    endcase
  end

  // Delay line and tap counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_k <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_dly[i] <= '0;
      end
    end else if (w_accept) begin
      r_k      <= '0;
      r_dly[0] <= s_axis_data_tdata;
      for (int unsigned i = 1; i < NTAPS; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end else if (w_mac_en) begin
      r_k <= r_k + KW'(1);
    end
  end

  // Shared MAC: tap r_k of the delay line against coefficient r_k.
  fir_mac #(
    .AW    (DW),
    .BW    (CW),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_clr   (w_mac_clr),
    .i_en    (w_mac_en),
    .i_a     (r_dly[r_k]),
    .i_b     (w_coef[r_k]),
    .o_acc   (w_acc)
  );

  // Output handshake registers; tdata holds between strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tready <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
    end else begin
      r_tready <= w_tready_nxt;
      r_mvalid <= w_out_load;
      if (w_out_load) begin
        r_mdata <= OW'(w_acc);
      end
    end
  end

  assign s_axis_data_tready = r_tready;
  assign m_axis_data_tvalid = r_mvalid;
  assign m_axis_data_tdata  = r_mdata;

endmodule : fir_compiler

// File: tb/tb_fir_compiler.sv
// ---------------------------------------------------------------------------
// tb_fir_compiler
// Scoreboard bench: a reference FIR model pushes the expected result for every
// accepted sample; the monitor pops and compares on each output strobe, along
// with latency and strobe spacing. Instance A uses the default coefficients,
// instance B uses all -32768 to exercise the full accumulator width.
// ---------------------------------------------------------------------------
module tb_fir_compiler;

  localparam int NT  = 16;
  localparam int LAT = NT + 1;

  typedef struct {
    logic [47:0] y;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        aresetn;
  logic        cfg_tvalid;
  logic        rld_tvalid;

  logic        tvalid_a, tready_a, mv_a;
  logic [23:0] tdata_a;
  logic [47:0] md_a;
  logic        tvalid_b, tready_b, mv_b;
  logic [23:0] tdata_b;
  logic [47:0] md_b;

  int total;
  int bad;
  int cyc;

  int     h_a [NT] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
  longint hist_a [NT];
  longint hist_b [NT];

  exp_t        q_a [$];
  exp_t        q_b [$];
  logic [47:0] log_a [$];
  logic [47:0] log_b [$];
  int          n_out_a;
  int          n_out_b;
  int          last_cyc_a;
  int          last_cyc_b;

  fir_compiler u_dut_a (
    .aclk                 (clk),
    .aresetn              (aresetn),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_reload_tvalid (rld_tvalid),
    .s_axis_data_tvalid   (tvalid_a),
    .s_axis_data_tready   (tready_a),
    .s_axis_data_tdata    (tdata_a),
    .m_axis_data_tvalid   (mv_a),
    .m_axis_data_tdata    (md_a)
  );

  fir_compiler #(
    .COEFFS ({16{16'h8000}})
  ) u_dut_b (
    .aclk                 (clk),
    .aresetn              (aresetn),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_reload_tvalid (rld_tvalid),
    .s_axis_data_tvalid   (tvalid_b),
    .s_axis_data_tready   (tready_b),
    .s_axis_data_tdata    (tdata_b),
    .m_axis_data_tvalid   (mv_b),
    .m_axis_data_tdata    (md_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: shift the accepted sample in and compute the sum.
  always @(posedge clk) begin
    longint acc;
    cyc = cyc + 1;
    if (aresetn) begin
      if (tvalid_a && tready_a) begin
        for (int k = NT - 1; k > 0; k--) hist_a[k] = hist_a[k-1];
        hist_a[0] = longint'($signed(tdata_a));
        acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(h_a[k]) * hist_a[k];
        q_a.push_back('{y: 48'(acc), cyc: cyc});
      end
      if (tvalid_b && tready_b) begin
        for (int k = NT - 1; k > 0; k--) hist_b[k] = hist_b[k-1];
        hist_b[0] = longint'($signed(tdata_b));
        acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(-32768) * hist_b[k];
        q_b.push_back('{y: 48'(acc), cyc: cyc});
      end
    end
  end

  // Monitor: compare each strobe against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mv_a) begin
      if (q_a.size() == 0) begin
        check("spurious_a", 64'(md_a), 64'hDEAD);
      end else begin
        e = q_a.pop_front();
        check("y_a", 64'(md_a), 64'(e.y));
        check("latency_a", 64'(cyc - e.cyc), 64'(LAT));
        check("spacing_a", 64'((cyc - last_cyc_a) >= NT + 2), 64'd1);
      end
      last_cyc_a = cyc;
      log_a.push_back(md_a);
      n_out_a++;
    end
    if (mv_b) begin
      if (q_b.size() == 0) begin
        check("spurious_b", 64'(md_b), 64'hDEAD);
      end else begin
        e = q_b.pop_front();
        check("y_b", 64'(md_b), 64'(e.y));
        check("latency_b", 64'(cyc - e.cyc), 64'(LAT));
      end
      last_cyc_b = cyc;
      log_b.push_back(md_b);
      n_out_b++;
    end
  end

  // Present one sample with tvalid held until it is accepted; call at a negedge.
  task automatic send(input bit sel_b, input logic [23:0] x);
    int n;
    n = 0;
    if (sel_b) begin tvalid_b = 1'b1; tdata_b = x; end
    else       begin tvalid_a = 1'b1; tdata_a = x; end
    while (!(sel_b ? tready_b : tready_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(sel_b ? tready_b : tready_a)) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
    end
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q_a.size() == 0 && q_b.size() == 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < NT; k++) begin
      hist_a[k] = 0;
      hist_b[k] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int saved;
    total = 0; bad = 0; cyc = 0;
    n_out_a = 0; n_out_b = 0;
    last_cyc_a = -1000; last_cyc_b = -1000;
    cfg_tvalid = 1'b0; rld_tvalid = 1'b0;
    clear_model();

    // Reset held with tvalid asserted.
    aresetn  = 1'b0;
    tvalid_a = 1'b1; tdata_a = 24'h123456;
    tvalid_b = 1'b1; tdata_b = 24'h654321;
    repeat (10) @(negedge clk);
    check("rst_tready_a", 64'(tready_a), 64'd0);
    check("rst_mvalid_a", 64'(mv_a), 64'd0);
    check("rst_mdata_a", 64'(md_a), 64'd0);
    check("rst_tready_b", 64'(tready_b), 64'd0);
    tvalid_a = 1'b0; tvalid_b = 1'b0;
    aresetn  = 1'b1;
    #1;
    check("tready_before_edge", 64'(tready_a), 64'd0);
    @(negedge clk);
    check("tready_after_edge", 64'(tready_a), 64'd1);

    // Impulse response.
    log_a.delete();
    send(1'b0, 24'd1);
    for (int i = 0; i < 31; i++) send(1'b0, 24'd0);
    drain();
    check("imp_count", 64'(log_a.size()), 64'd32);
    check("imp_y0", 64'(log_a[0]), 64'd1);
    check("imp_y7", 64'(log_a[7]), 64'd8);
    check("imp_y8", 64'(log_a[8]), 64'd8);
    check("imp_y15", 64'(log_a[15]), 64'd1);
    check("imp_y16", 64'(log_a[16]), 64'd0);

    // Step response.
    log_a.delete();
    for (int i = 0; i < 24; i++) send(1'b0, 24'h000001);
    drain();
    check("step_count", 64'(log_a.size()), 64'd24);
    check("step_y2", 64'(log_a[2]), 64'd6);
    check("step_steady", 64'(log_a[23]), 64'h48);
    check("hold_mdata", 64'(md_a), 64'h48);

    // Negative full-scale impulse from a flushed delay line.
    for (int i = 0; i < NT; i++) send(1'b0, 24'd0);
    drain();
    log_a.delete();
    send(1'b0, 24'h800000);
    for (int i = 0; i < 15; i++) send(1'b0, 24'd0);
    drain();
    check("neg_y0", 64'(log_a[0]), 64'h0000_FFFF_FF80_0000);
    check("neg_y7", 64'(log_a[7]), 64'h0000_FFFF_FC00_0000);

    // Full-width accumulation on instance B.
    log_b.delete();
    for (int i = 0; i < 20; i++) send(1'b1, 24'h800000);
    drain();
    check("width_count", 64'(log_b.size()), 64'd20);
    check("width_y0", 64'(log_b[0]), 64'h0000_0040_0000_0000);
    check("width_steady", 64'(log_b[19]), 64'h0000_0400_0000_0000);

    // Irregular tvalid with reserved channels toggling.
    saved = n_out_a;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 5)) begin
        cfg_tvalid = 1'($urandom_range(0, 1));
        rld_tvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      send(1'b0, 24'($urandom));
    end
    cfg_tvalid = 1'b0; rld_tvalid = 1'b0;
    drain();
    check("hs_pulses", 64'(n_out_a - saved), 64'd20);

    // Reset during a computation: no strobe, then a clean impulse response.
    send(1'b0, 24'h00ABCD);
    repeat (4) @(negedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    clear_model();
    saved = n_out_a;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_out", 64'(n_out_a), 64'(saved));
    log_a.delete();
    send(1'b0, 24'd1);
    for (int i = 0; i < 15; i++) send(1'b0, 24'd0);
    drain();
    check("midrst_y0", 64'(log_a[0]), 64'd1);
    check("midrst_y8", 64'(log_a[8]), 64'd8);
    check("midrst_y15", 64'(log_a[15]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fir_compiler
